// File: rtl/wts_pkg.sv
// Shared constants and types for the wave-table channel noise mixer.
package wts_pkg;

   localparam int CH_NUM = 5;
   localparam int CH_W   = 3;
   localparam int SMP_W  = 8;
   localparam int VOL_W  = 4;
   localparam int TERM_W = SMP_W + VOL_W;
   localparam int MIX_W  = 15;

   localparam logic signed [SMP_W-1:0] NOISE_HI = 8'sh7f;
   localparam logic signed [SMP_W-1:0] NOISE_LO = 8'sh80;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      CAPTURE,
      ACCUM
   } mix_state_t;

endpackage

// File: rtl/wts_mix_if.sv
// Wave/volume read port plus the mixed-sample output bundle.
interface wts_mix_if;
   import wts_pkg::*;

   logic [CH_W-1:0]         ch_sel;
   logic signed [SMP_W-1:0] ch_wave;
   logic [VOL_W-1:0]        ch_volume;
   logic signed [MIX_W-1:0] mix_out;
   logic                    mix_valid;

   modport master (
      output ch_sel,
      output mix_out,
      output mix_valid,
      input  ch_wave,
      input  ch_volume
   );

   modport slave (
      input  ch_sel,
      input  mix_out,
      input  mix_valid,
      output ch_wave,
      output ch_volume
   );

endinterface

// File: rtl/wts_mix_term.sv
// Per-channel source select (wave or noise extreme) and volume scaling.
module wts_mix_term
   import wts_pkg::*;
(
   input  logic                     noise_sel,
   input  logic                     noise,
   input  logic                     ch_en,
   input  logic signed [SMP_W-1:0]  wave,
   input  logic [VOL_W-1:0]         vol,
   output logic signed [TERM_W-1:0] term
);

   logic signed [SMP_W-1:0]  src;
   logic signed [VOL_W:0]    vol_s;
   logic signed [TERM_W:0]   prod;

   always_comb begin
      src   = noise_sel ? (noise ? NOISE_HI : NOISE_LO) : wave;
      vol_s = $signed({1'b0, vol});
      prod  = src * vol_s;
      // -128*15 and 127*15 both fit TERM_W, top product bit is redundant
      term  = ch_en ? prod[TERM_W-1:0] : '0;
   end

endmodule

// File: rtl/wts_channel_noise_mixer.sv
// Sequences CH_NUM channels per frame and publishes their scaled sum.
module wts_channel_noise_mixer
   import wts_pkg::*;
(
   input  logic              clk,
   input  logic              nreset,
   input  logic              active,
   input  logic              noise,
   input  logic [CH_NUM-1:0] reg_noise_en,
   input  logic [CH_NUM-1:0] reg_ch_en,
   wts_mix_if.master         bus
);

   mix_state_t               state_q, state_d;
   logic [CH_W-1:0]          ch_cnt_q, ch_cnt_d;
   logic [CH_W-1:0]          ch_sel_q, ch_sel_d;
   logic signed [TERM_W-1:0] term_q, term_d;
   logic signed [MIX_W-1:0]  acc_q, acc_d;
   logic signed [MIX_W-1:0]  mix_out_q, mix_out_d;
   logic                     mix_valid_q, mix_valid_d;

   logic signed [TERM_W-1:0] term_w;
   logic signed [MIX_W-1:0]  term_ext;
   logic signed [MIX_W-1:0]  sum_w;

   wts_mix_term u_term (
      .noise_sel (reg_noise_en[ch_sel_q]),
      .noise     (noise),
      .ch_en     (reg_ch_en[ch_sel_q]),
      .wave      (bus.ch_wave),
      .vol       (bus.ch_volume),
      .term      (term_w)
   );

   assign term_ext = {{(MIX_W-TERM_W){term_q[TERM_W-1]}}, term_q};
   assign sum_w    = acc_q + term_ext;

   always_comb begin
      state_d     = state_q;
      ch_cnt_d    = ch_cnt_q;
      ch_sel_d    = ch_sel_q;
      term_d      = term_q;
      acc_d       = acc_q;
      mix_out_d   = mix_out_q;
      mix_valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (active) begin
               ch_sel_d = ch_cnt_q;
               state_d  = FETCH;
            end
         end
         FETCH: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            term_d  = term_w;
            state_d = ACCUM;
         end
         ACCUM: begin
            if (ch_cnt_q == CH_W'(CH_NUM-1)) begin
               mix_out_d   = sum_w;
               mix_valid_d = 1'b1;
               acc_d       = '0;
               ch_cnt_d    = '0;
            end else begin
               acc_d    = sum_w;
               ch_cnt_d = ch_cnt_q + 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q     <= IDLE;
         ch_cnt_q    <= '0;
         ch_sel_q    <= '0;
         term_q      <= '0;
         acc_q       <= '0;
         mix_out_q   <= '0;
         mix_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_cnt_q    <= ch_cnt_d;
         ch_sel_q    <= ch_sel_d;
         term_q      <= term_d;
         acc_q       <= acc_d;
         mix_out_q   <= mix_out_d;
         mix_valid_q <= mix_valid_d;
      end
   end

   assign bus.ch_sel    = ch_sel_q;
   assign bus.mix_out   = mix_out_q;
   assign bus.mix_valid = mix_valid_q;

endmodule

// File: tb/tb_wts_channel_noise_mixer.sv
// Directed bench for the channel noise mixer with a 1-clk read-port model.
`timescale 1ns/1ps
module tb_wts_channel_noise_mixer;
   import wts_pkg::*;

   logic              clk = 1'b0;
   logic              nreset = 1'b1;
   logic              active = 1'b0;
   logic              noise = 1'b0;
   logic [CH_NUM-1:0] reg_noise_en = '0;
   logic [CH_NUM-1:0] reg_ch_en = '0;

   logic signed [SMP_W-1:0] wave_tbl [CH_NUM];
   logic [VOL_W-1:0]        vol_tbl  [CH_NUM];

   int vectors = 0;
   int errors  = 0;
   int frame_nv;
   int frame_pos;

   wts_mix_if bus ();

   wts_channel_noise_mixer dut (
      .clk          (clk),
      .nreset       (nreset),
      .active       (active),
      .noise        (noise),
      .reg_noise_en (reg_noise_en),
      .reg_ch_en    (reg_ch_en),
      .bus          (bus)
   );

   always #23.28 clk = ~clk;

   always @(posedge clk) begin
      bus.ch_wave   <= wave_tbl[bus.ch_sel];
      bus.ch_volume <= vol_tbl[bus.ch_sel];
   end

   task automatic chk(input string tag,
                      input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // nch pulses spaced 6 clks; storm adds pulses while in FETCH and CAPTURE
   task automatic run_frame(input int nch, input bit storm);
      frame_nv  = 0;
      frame_pos = -1;
      for (int i = 0; i < nch; i++) begin
         for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 1) chk("ch_sel", 32'(bus.ch_sel), i);
            if (bus.mix_valid === 1'b1) begin
               frame_nv++;
               frame_pos = i * 6 + j;
            end
            active = (j == 0) || (storm && (j == 1 || j == 2));
         end
      end
      @(negedge clk);
      active = 1'b0;
      if (bus.mix_valid === 1'b1) frame_nv++;
   endtask

   task automatic check_frame(input string tag, input int exp);
      run_frame(CH_NUM, 1'b0);
      chk({tag, "_mix"}, 32'(bus.mix_out), exp);
      chk({tag, "_nvalid"}, frame_nv, 1);
      chk({tag, "_lat"}, frame_pos, CH_NUM * 6 - 2);
   endtask

   task automatic set_wave_cfg();
      wave_tbl[0] = 8'sd10;
      wave_tbl[1] = -8'sd20;
      wave_tbl[2] = 8'sd30;
      wave_tbl[3] = -8'sd40;
      wave_tbl[4] = 8'sd50;
      for (int i = 0; i < CH_NUM; i++) vol_tbl[i] = 4'd15;
      reg_ch_en    = '1;
      reg_noise_en = '0;
   endtask

   initial begin
      set_wave_cfg();
      #5 nreset = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         active = (k % 6 == 0);
         chk("rst_valid", 32'(bus.mix_valid), 0);
         chk("rst_sel", 32'(bus.ch_sel), 0);
      end
      active = 1'b0;
      chk("rst_mix", 32'(bus.mix_out), 0);
      @(negedge clk);
      nreset = 1'b1;

      check_frame("wave1", 450);
      check_frame("wave2", 450);

      reg_noise_en = '1;
      noise = 1'b1;
      check_frame("noise_hi", CH_NUM * 127 * 15);
      noise = 1'b0;
      check_frame("noise_lo", -9600);

      set_wave_cfg();
      wave_tbl[0] = -8'sd128;
      reg_ch_en   = 5'b00001;
      check_frame("gate_ch0", -1920);
      reg_ch_en   = '0;
      check_frame("gate_none", 0);

      set_wave_cfg();
      run_frame(CH_NUM, 1'b1);
      chk("storm_mix", 32'(bus.mix_out), 450);
      chk("storm_nvalid", frame_nv, 1);
      chk("storm_lat", frame_pos, CH_NUM * 6 - 2);

      run_frame(3, 1'b0);
      chk("part_nvalid", frame_nv, 0);
      @(negedge clk);
      nreset = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_sel", 32'(bus.ch_sel), 0);
      chk("midrst_mix", 32'(bus.mix_out), 0);
      nreset = 1'b1;
      check_frame("after_rst", 450);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
